// File: rtl/block_add_sequencer.sv
// block_add_sequencer: W-bit add (or subtract) of two operands, computed one
// byte per cycle through a single 8-bit ripple-carry slice, LSB byte first.
// Optional feature macro: SEQ_SUB_EN adds the 'op' port (1 = a - b).
// Handshake: in_valid/in_ready to start; out_valid/out_ready to retire.
module block_add_sequencer #(
  parameter int BEATS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*BEATS-1:0] a,
  input  logic [8*BEATS-1:0] b,
  input  logic               cin,
`ifdef SEQ_SUB_EN
  input  logic               op,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*BEATS-1:0] sum,
  output logic               cout,
  output logic               ovf
);

  localparam int W  = 8 * BEATS;
  localparam int KW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, b_q, sum_q;
  logic [KW-1:0]   k_q;
  logic [KW+2:0]   byte_idx;
  logic            carry_q, cout_q, ovf_q;
  logic            ready_en_q;
  logic            sub_q;
  logic            accept, last_beat;

  // Slice signals for the byte currently being processed.
  logic [7:0]      a_byte, b_byte, s_byte;
  logic            c_out, c_msb_in;

  assign in_ready  = (state_q == S_IDLE) && ready_en_q;
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid && in_ready;
  assign last_beat = (k_q == KW'(BEATS - 1));
  assign byte_idx  = {k_q, 3'b000};

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

`ifndef SEQ_SUB_EN
  assign sub_q = 1'b0;
`endif

  // State register.
  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after the last beat,
  // DONE -> IDLE when the consumer takes the result.
  // NOTE: state_d gets its default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept)    state_d = S_RUN;
      S_RUN:  if (last_beat) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // One 8-bit ripple-carry slice; b is inverted per byte when subtracting.
  always_comb begin
    a_byte            = a_q[byte_idx +: 8];
    b_byte            = b_q[byte_idx +: 8] ^ {8{sub_q}};
    {c_out, s_byte}   = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry_q};
    // Carry into bit 7 recovered from the sum bit: s7 = a7 ^ b7 ^ c7.
    c_msb_in          = a_byte[7] ^ b_byte[7] ^ s_byte[7];
  end

  // Operand latch, beat counter, carry chain and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      k_q        <= '0;
      carry_q    <= 1'b0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ready_en_q <= 1'b0;
`ifdef SEQ_SUB_EN
      sub_q      <= 1'b0;
`endif
    end else begin
      // Holds in_ready low through reset and raises it on the first edge after.
      ready_en_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            a_q    <= a;
            b_q    <= b;
            k_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
`ifdef SEQ_SUB_EN
            sub_q   <= op;
            // Subtraction is a + ~b + 1, so the caller's carry-in is ignored.
            carry_q <= op ? 1'b1 : cin;
`else
            carry_q <= cin;
`endif
          end
        end
        S_RUN: begin
          sum_q[byte_idx +: 8] <= s_byte;
          carry_q              <= c_out;
          k_q                  <= k_q + 1'b1;
          if (last_beat) begin
            k_q    <= '0;
            cout_q <= c_out;
            ovf_q  <= c_msb_in ^ c_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_block_add_sequencer.sv
// Self-checking bench for block_add_sequencer (BEATS = 4). A cycle-level
// transaction model predicts handshake and results from plain W-bit arithmetic;
// a compare process checks the DUT against it on every falling edge, and the
// directed sequence pins the model with hand-computed results.
module tb_block_add_sequencer;

  localparam int BEATS = 4;
  localparam int W     = 8 * BEATS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         cin = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, cout, ovf;
  logic [W-1:0] sum;

  int n_cmp  = 0;
  int n_fail = 0;

  block_add_sequencer #(.BEATS(BEATS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SEQ_SUB_EN
    .op        (op),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  bit           m_ready_ok, m_busy, m_done;
  int           m_cnt;
  logic [W-1:0] e_sum;
  bit           e_cout, e_ovf;

  task automatic model_result(input logic [W-1:0] ma, input logic [W-1:0] mb,
                              input logic mc, input logic mop);
    logic [W:0]   full;
    logic [W-1:0] bb;
    logic         c0;
    bb = mb;
    c0 = mc;
`ifdef SEQ_SUB_EN
    if (mop) begin
      bb = ~mb;
      c0 = 1'b1;
    end
`endif
    full   = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, c0};
    e_sum  = full[W-1:0];
    e_cout = full[W];
    e_ovf  = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready_ok = 0;
      m_busy     = 0;
      m_done     = 0;
      m_cnt      = 0;
    end else begin
      bit acc, cons;
      acc  = in_valid && m_ready_ok && !m_busy;
      cons = m_done && out_ready;
      if (cons) begin
        m_busy = 0;
        m_done = 0;
      end else if (m_busy && !m_done) begin
        m_cnt++;
        if (m_cnt == BEATS) m_done = 1;
      end
      if (acc) begin
        m_busy = 1;
        m_cnt  = 0;
        model_result(a, b, cin, op);
      end
      m_ready_ok = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_in_ready",  in_ready,  0);
      check("rst_out_valid", out_valid, 0);
      check("rst_sum",       sum,       0);
      check("rst_cout",      cout,      0);
      check("rst_ovf",       ovf,       0);
    end else begin
      check("in_ready",  in_ready,  m_ready_ok && !m_busy);
      check("out_valid", out_valid, m_done);
      if (m_done) begin
        check("sum",  sum,  e_sum);
        check("cout", cout, e_cout);
        check("ovf",  ovf,  e_ovf);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_ready();
    int t;
    t = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_seen", in_ready, 1);
  endtask

  task automatic run(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                     input logic tc, input logic top,
                     input logic [W-1:0] x_sum, input logic x_cout, input logic x_ovf,
                     input int hold, input bit stray, input bit early);
    int lat;
    logic [W-1:0] h_sum;
    logic h_cout, h_ovf;
    wait_ready();
    a = ta; b = tb; cin = tc; op = top; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = early;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      @(posedge clk);
      #1 lat++;
      if (lat == 2) out_ready = 1'b0;
    end
    check({name, "_latency"}, lat, BEATS);
    out_ready = 1'b0;
    h_sum = sum; h_cout = cout; h_ovf = ovf;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (stray && i >= 2 && i < 5) begin
        in_valid = 1'b1;
        a = ~ta; b = 32'h5A5A_5A5A; cin = ~tc;
      end else begin
        in_valid = 1'b0;
      end
    end
    if (hold > 0) begin
      check({name, "_hold_sum"},  sum,  h_sum);
      check({name, "_hold_cout"}, cout, h_cout);
      check({name, "_hold_ovf"},  ovf,  h_ovf);
    end
    in_valid = 1'b0;
    // Hand-computed expectations pin both DUT and model.
    check({name, "_sum"},       sum,    x_sum);
    check({name, "_cout"},      cout,   x_cout);
    check({name, "_ovf"},       ovf,    x_ovf);
    check({name, "_model_sum"}, e_sum,  x_sum);
    check({name, "_model_ovf"}, e_ovf,  x_ovf);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({name, "_ready_after_consume"}, in_ready, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("ready_before_first_edge", in_ready, 0);
    @(posedge clk);
    #1 check("ready_first_edge", in_ready, 1);

    run("carry_byte",  32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 0,  0, 0);
    run("full_wrap",   32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0,  0, 1);
    run("pos_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 10, 1, 0);
    run("mixed",       32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0, 2,  0, 0);
    run("neg_ovf",     32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 0,  0, 0);

    // Reset in the middle of RUN: everything clears at once, no result appears.
    wait_ready();
    a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0; op = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_out_valid", out_valid, 0);
    check("midrun_rst_sum",       sum,       0);
    check("midrun_rst_cout",      cout,      0);
    check("midrun_rst_ovf",       ovf,       0);
    check("midrun_rst_in_ready",  in_ready,  0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run("after_rst",   32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0, 0,  0, 0);

`ifdef SEQ_SUB_EN
    run("sub_borrow",  32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 0,  0, 0);
    run("sub_noborrow",32'h0000_0010, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_000D, 1'b1, 1'b0, 0,  0, 0);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
